// File: rtl/gpio_scan_ctrl.sv
// gpio_scan_ctrl: GPIO scan-packet responder that drives one dual-port SRAM access per global_csb strobe.
// Optional GPIO_SCAN_PARITY_EN adds an even-parity bit at packet bit 0 and a sticky parity_err output.
module gpio_scan_ctrl #(
    parameter int NUM_SRAM = 12,
    parameter int ADDR_W   = 16
) (
    input  logic                     gpio_clk,
    input  logic                     gpio_resetn,
    input  logic                     gpio_in,
    input  logic                     gpio_scan,
    input  logic                     gpio_sram_load,
    input  logic                     global_csb,
    output logic                     gpio_out,
`ifdef GPIO_SCAN_PARITY_EN
    output logic                     parity_err,
`endif
    output logic [NUM_SRAM-1:0]      sram_csb0,
    output logic [NUM_SRAM-1:0]      sram_csb1,
    output logic                     sram_web0,
    output logic                     sram_web1,
    output logic [ADDR_W-1:0]        sram_addr0,
    output logic [ADDR_W-1:0]        sram_addr1,
    output logic [31:0]              sram_din0,
    output logic [31:0]              sram_din1,
    output logic [3:0]               sram_wmask0,
    output logic [3:0]               sram_wmask1,
    input  logic [NUM_SRAM*32-1:0]   sram_dout0,
    input  logic [NUM_SRAM*32-1:0]   sram_dout1
);

`ifdef GPIO_SCAN_PARITY_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif
    localparam int PW        = 112 + OFF;
    localparam int SEL_LSB   = OFF + 108;
    localparam int ADDR0_LSB = OFF + 92;
    localparam int DIN0_LSB  = OFF + 60;
    localparam int CSB0_BIT  = OFF + 59;
    localparam int WEB0_BIT  = OFF + 58;
    localparam int WM0_LSB   = OFF + 54;
    localparam int ADDR1_LSB = OFF + 38;
    localparam int DIN1_LSB  = OFF + 6;
    localparam int CSB1_BIT  = OFF + 5;
    localparam int WEB1_BIT  = OFF + 4;
    localparam int WM1_LSB   = OFF;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] shiftReg_q, shiftReg_d;
    logic [31:0]   dout0_q, dout0_d;
    logic [31:0]   dout1_q, dout1_d;

    logic [3:0]    selF;
    logic [15:0]   addr0F, addr1F;
    logic [31:0]   din0F, din1F;
    logic          csb0F, web0F, csb1F, web1F;
    logic [3:0]    wmask0F, wmask1F;
    logic [31:0]   rdData0, rdData1;
    logic          accessCycle;
    logic          accessGo;

    assign selF    = shiftReg_q[SEL_LSB +: 4];
    assign addr0F  = shiftReg_q[ADDR0_LSB +: 16];
    assign din0F   = shiftReg_q[DIN0_LSB +: 32];
    assign csb0F   = shiftReg_q[CSB0_BIT];
    assign web0F   = shiftReg_q[WEB0_BIT];
    assign wmask0F = shiftReg_q[WM0_LSB +: 4];
    assign addr1F  = shiftReg_q[ADDR1_LSB +: 16];
    assign din1F   = shiftReg_q[DIN1_LSB +: 32];
    assign csb1F   = shiftReg_q[CSB1_BIT];
    assign web1F   = shiftReg_q[WEB1_BIT];
    assign wmask1F = shiftReg_q[WM1_LSB +: 4];

    assign accessCycle = !global_csb && !gpio_scan;

`ifdef GPIO_SCAN_PARITY_EN
    logic parityErr_q, parityErr_d;
    logic parityBad;

    assign parityBad   = ^shiftReg_q;
    assign accessGo    = accessCycle && !parityBad;
    assign parityErr_d = parityErr_q || (accessCycle && parityBad);
    assign parity_err  = parityErr_q;

    always_ff @(posedge gpio_clk or negedge gpio_resetn) begin
        if (!gpio_resetn) begin
            parityErr_q <= 1'b0;
        end else begin
            parityErr_q <= parityErr_d;
        end
    end
`else
    assign accessGo = accessCycle;
`endif

    assign gpio_out    = shiftReg_q[PW-1];
    assign sram_web0   = web0F;
    assign sram_web1   = web1F;
    assign sram_addr0  = addr0F[ADDR_W-1:0];
    assign sram_addr1  = addr1F[ADDR_W-1:0];
    assign sram_din0   = din0F;
    assign sram_din1   = din1F;
    assign sram_wmask0 = wmask0F;
    assign sram_wmask1 = wmask1F;

    // Reset gates the selects too, so an in-flight access is dropped the instant reset asserts.
    always_comb begin
        sram_csb0 = '1;
        sram_csb1 = '1;
        if (gpio_resetn && accessGo) begin
            for (int k = 0; k < NUM_SRAM; k++) begin
                if (int'(selF) == k) begin
                    sram_csb0[k] = csb0F;
                    sram_csb1[k] = csb1F;
                end
            end
        end
    end

    always_comb begin
        rdData0 = '0;
        rdData1 = '0;
        for (int k = 0; k < NUM_SRAM; k++) begin
            if (int'(selF) == k) begin
                rdData0 = sram_dout0[k*32 +: 32];
                rdData1 = sram_dout1[k*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d    = accessGo ? ACCESS : IDLE;
        dout0_d    = dout0_q;
        dout1_d    = dout1_q;
        shiftReg_d = shiftReg_q;
        // sel/csb/web still hold the access-cycle values here: no shift can happen while in ACCESS.
        if (state_q == ACCESS) begin
            dout0_d = (!csb0F && web0F) ? rdData0 : 32'h0;
            dout1_d = (!csb1F && web1F) ? rdData1 : 32'h0;
        end
        if (gpio_sram_load) begin
            shiftReg_d[DIN0_LSB +: 32] = dout0_q;
            shiftReg_d[DIN1_LSB +: 32] = dout1_q;
        end else if (gpio_scan) begin
            shiftReg_d = {shiftReg_q[PW-2:0], gpio_in};
        end
    end

    always_ff @(posedge gpio_clk or negedge gpio_resetn) begin
        if (!gpio_resetn) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            dout0_q    <= '0;
            dout1_q    <= '0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            dout0_q    <= dout0_d;
            dout1_q    <= dout1_d;
        end
    end

endmodule

// File: tb/tb_gpio_scan_ctrl.sv
// tb_gpio_scan_ctrl: directed bench for gpio_scan_ctrl with a small dual-port SRAM/ROM model behind it.
module tb_gpio_scan_ctrl;

    localparam int NUM_SRAM = 12;
    localparam int ADDR_W   = 16;

    logic                   gpio_clk;
    logic                   gpio_resetn;
    logic                   gpio_in;
    logic                   gpio_scan;
    logic                   gpio_sram_load;
    logic                   global_csb;
    logic                   gpio_out;
    logic [NUM_SRAM-1:0]    sram_csb0, sram_csb1;
    logic                   sram_web0, sram_web1;
    logic [ADDR_W-1:0]      sram_addr0, sram_addr1;
    logic [31:0]            sram_din0, sram_din1;
    logic [3:0]             sram_wmask0, sram_wmask1;
    logic [NUM_SRAM*32-1:0] sram_dout0, sram_dout1;

    int testsRun    = 0;
    int testsFailed = 0;

    gpio_scan_ctrl #(.NUM_SRAM(NUM_SRAM), .ADDR_W(ADDR_W)) dut (
        .gpio_clk       (gpio_clk),
        .gpio_resetn    (gpio_resetn),
        .gpio_in        (gpio_in),
        .gpio_scan      (gpio_scan),
        .gpio_sram_load (gpio_sram_load),
        .global_csb     (global_csb),
        .gpio_out       (gpio_out),
        .sram_csb0      (sram_csb0),
        .sram_csb1      (sram_csb1),
        .sram_web0      (sram_web0),
        .sram_web1      (sram_web1),
        .sram_addr0     (sram_addr0),
        .sram_addr1     (sram_addr1),
        .sram_din0      (sram_din0),
        .sram_din1      (sram_din1),
        .sram_wmask0    (sram_wmask0),
        .sram_wmask1    (sram_wmask1),
        .sram_dout0     (sram_dout0),
        .sram_dout1     (sram_dout1)
    );

    initial gpio_clk = 1'b0;
    always #5 gpio_clk = ~gpio_clk;

    // Memory model: 16 words per slot, both ports share one array; slot 11 is a ROM.
    logic [31:0] mem [NUM_SRAM][16];

    function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] din,
                                              input logic [3:0] mask);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++) if (mask[b]) w[b*8 +: 8] = din[b*8 +: 8];
        return w;
    endfunction

    function automatic logic [31:0] readWord(input int k, input logic [3:0] a);
        if (k == 11) return (a == 4'd1) ? 32'd255 : 32'd0;
        return mem[k][a];
    endfunction

    always @(posedge gpio_clk) begin
        for (int k = 0; k < NUM_SRAM; k++) begin
            if (!sram_csb0[k]) begin
                if (!sram_web0) mem[k][sram_addr0[3:0]] <= mergeWord(mem[k][sram_addr0[3:0]], sram_din0, sram_wmask0);
                else            sram_dout0[k*32 +: 32] <= readWord(k, sram_addr0[3:0]);
            end
            if (!sram_csb1[k]) begin
                if (!sram_web1) mem[k][sram_addr1[3:0]] <= mergeWord(mem[k][sram_addr1[3:0]], sram_din1, sram_wmask1);
                else            sram_dout1[k*32 +: 32] <= readWord(k, sram_addr1[3:0]);
            end
        end
    end

    function automatic logic [111:0] mkPkt(
        input logic [3:0] sel, input logic [15:0] a0, input logic [31:0] d0,
        input logic c0, input logic w0, input logic [3:0] m0,
        input logic [15:0] a1, input logic [31:0] d1,
        input logic c1, input logic w1, input logic [3:0] m1);
        return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Shift a whole packet in MSB first; returns just after a falling edge with scan low.
    task automatic applyStimulus(input logic [111:0] p);
        for (int i = 111; i >= 0; i--) begin
            @(negedge gpio_clk);
            gpio_scan = 1'b1;
            gpio_in   = p[i];
        end
        @(negedge gpio_clk);
        gpio_scan = 1'b0;
        gpio_in   = 1'b0;
    endtask

    task automatic runAccess(input string tag, input logic [11:0] exp0, input logic [11:0] exp1);
        global_csb = 1'b0;
        #1;
        checkOutput({tag, "_csb0"}, 128'(sram_csb0), 128'(exp0));
        checkOutput({tag, "_csb1"}, 128'(sram_csb1), 128'(exp1));
        @(negedge gpio_clk);
        global_csb = 1'b1;
        #1;
        checkOutput({tag, "_csb0_rel"}, 128'(sram_csb0), 128'(12'hFFF));
        checkOutput({tag, "_csb1_rel"}, 128'(sram_csb1), 128'(12'hFFF));
        @(negedge gpio_clk);
    endtask

    task automatic loadCapture();
        gpio_sram_load = 1'b1;
        @(negedge gpio_clk);
        gpio_sram_load = 1'b0;
    endtask

    task automatic readBack(input string tag, input logic [111:0] exp);
        logic [111:0] got;
        loadCapture();
        for (int i = 111; i >= 0; i--) begin
            got[i]    = gpio_out;
            gpio_scan = 1'b1;
            gpio_in   = 1'b0;
            @(negedge gpio_clk);
        end
        gpio_scan = 1'b0;
        checkOutput({tag, "_pkt"},  128'(got), 128'(exp));
        checkOutput({tag, "_din0"}, 128'(got[91:60]), 128'(exp[91:60]));
        checkOutput({tag, "_din1"}, 128'(got[37:6]),  128'(exp[37:6]));
    endtask

    initial begin
        logic [111:0] q;
        gpio_resetn    = 1'b0;
        gpio_in        = 1'b0;
        gpio_scan      = 1'b0;
        gpio_sram_load = 1'b0;
        global_csb     = 1'b0;
        repeat (2) @(negedge gpio_clk);
        #1;
        checkOutput("rst_gpio_out", 128'(gpio_out), 128'(1'b0));
        checkOutput("rst_csb0", 128'(sram_csb0), 128'(12'hFFF));
        checkOutput("rst_csb1", 128'(sram_csb1), 128'(12'hFFF));
        global_csb = 1'b1;
        @(negedge gpio_clk);
        gpio_resetn = 1'b1;
        @(negedge gpio_clk);

        applyStimulus(mkPkt(4'd3, 16'd1, 32'd3, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
        checkOutput("mirror_addr0", 128'(sram_addr0), 128'(16'd1));
        checkOutput("mirror_din0", 128'(sram_din0), 128'(32'd3));
        checkOutput("mirror_web0", 128'(sram_web0), 128'(1'b0));
        checkOutput("mirror_wmask0", 128'(sram_wmask0), 128'(4'hF));
        runAccess("wr3a", 12'hFF7, 12'hFFF);
        applyStimulus(mkPkt(4'd3, 16'd2, 32'd24, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
        runAccess("wr3b", 12'hFF7, 12'hFFF);
        applyStimulus(mkPkt(4'd3, 16'd1, 32'h11111111, 1'b0, 1'b1, 4'hF, 16'd2, 32'h22222222, 1'b0, 1'b1, 4'hF));
        runAccess("rd3", 12'hFF7, 12'hFF7);
        readBack("rd3", mkPkt(4'd3, 16'd1, 32'd3, 1'b0, 1'b1, 4'hF, 16'd2, 32'd24, 1'b0, 1'b1, 4'hF));

        applyStimulus(mkPkt(4'd8, 16'd1, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
        runAccess("wr8", 12'hEFF, 12'hFFF);
        applyStimulus(mkPkt(4'd8, 16'd1, 32'd0, 1'b0, 1'b1, 4'hF, 16'd5, 32'hCAFEF00D, 1'b1, 1'b1, 4'hF));
        runAccess("rd8", 12'hEFF, 12'hFFF);
        readBack("rd8", mkPkt(4'd8, 16'd1, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF, 16'd5, 32'd0, 1'b1, 1'b1, 4'hF));

        applyStimulus(mkPkt(4'd11, 16'd1, 32'h55AA55AA, 1'b0, 1'b1, 4'h3, 16'hBEEF, 32'h12345678, 1'b1, 1'b1, 4'h5));
        runAccess("rom11", 12'h7FF, 12'hFFF);
        readBack("rom11", mkPkt(4'd11, 16'd1, 32'd255, 1'b0, 1'b1, 4'h3, 16'hBEEF, 32'd0, 1'b1, 1'b1, 4'h5));

        // Captured data is now din0=255, din1=0; exercise both priority cases.
        q = mkPkt(4'd10, 16'h00FF, 32'h0F0F0F0F, 1'b1, 1'b1, 4'h0, 16'h1234, 32'hFFFF0000, 1'b1, 1'b1, 4'h0);
        applyStimulus(q);
        global_csb = 1'b0;
        gpio_scan  = 1'b1;
        gpio_in    = 1'b1;
        #1;
        checkOutput("prio_scan_csb0", 128'(sram_csb0), 128'(12'hFFF));
        checkOutput("prio_scan_csb1", 128'(sram_csb1), 128'(12'hFFF));
        @(negedge gpio_clk);
        global_csb = 1'b1;
        gpio_scan  = 1'b0;
        #1;
        checkOutput("prio_scan_out", 128'(gpio_out), 128'(1'b0));
        checkOutput("prio_scan_addr0", 128'(sram_addr0), 128'(16'h01FE));
        gpio_sram_load = 1'b1;
        gpio_scan      = 1'b1;
        gpio_in        = 1'b1;
        @(negedge gpio_clk);
        gpio_sram_load = 1'b0;
        gpio_scan      = 1'b0;
        gpio_in        = 1'b0;
        #1;
        checkOutput("prio_load_out", 128'(gpio_out), 128'(1'b0));
        checkOutput("prio_load_din0", 128'(sram_din0), 128'(32'd255));
        checkOutput("prio_load_din1", 128'(sram_din1), 128'(32'd0));
        checkOutput("prio_load_addr0", 128'(sram_addr0), 128'(16'h01FE));

        applyStimulus(mkPkt(4'd14, 16'd7, 32'h13579BDF, 1'b0, 1'b1, 4'hF, 16'd9, 32'h2468ACE0, 1'b0, 1'b1, 4'hF));
        runAccess("unmap14", 12'hFFF, 12'hFFF);
        readBack("unmap14", mkPkt(4'd14, 16'd7, 32'd0, 1'b0, 1'b1, 4'hF, 16'd9, 32'd0, 1'b0, 1'b1, 4'hF));

        applyStimulus(mkPkt(4'd11, 16'd1, 32'h55AA55AA, 1'b0, 1'b1, 4'h3, 16'hBEEF, 32'h12345678, 1'b1, 1'b1, 4'h5));
        global_csb = 1'b0;
        @(posedge gpio_clk);
        #2;
        gpio_resetn = 1'b0;
        #1;
        checkOutput("midrst_csb0", 128'(sram_csb0), 128'(12'hFFF));
        checkOutput("midrst_csb1", 128'(sram_csb1), 128'(12'hFFF));
        checkOutput("midrst_gpio_out", 128'(gpio_out), 128'(1'b0));
        @(negedge gpio_clk);
        global_csb  = 1'b1;
        gpio_resetn = 1'b1;
        @(negedge gpio_clk);
        loadCapture();
        #1;
        checkOutput("midrst_din0", 128'(sram_din0), 128'(32'd0));
        checkOutput("midrst_din1", 128'(sram_din1), 128'(32'd0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/gpio_scan_ctrl.md
# gpio_scan_ctrl

On-chip responder for the GPIO scan test interface: deserialises the 112-bit scan packet shifted in on `gpio_in`, and on a `global_csb` strobe drives one dual-port SRAM access to the memory picked by `sel`. It then captures read data and reloads it into the packet's `din` fields, so the same packet scans back out on `gpio_out`. It sits between the GPIO pads (test-mode select) and the SRAM/ROM macro array.

## Interface
- `NUM_SRAM`, 12: number of memory slots; `sel` values at or above this are unmapped.
- `ADDR_W`, 16: address width driven to the macros (the packet always carries 16 bits).
- `gpio_clk  in  1`: scan/access clock.
- `gpio_resetn  in  1`: asynchronous, active-low reset.
- `gpio_in  in  1`: serial data in, MSB first.
- `gpio_scan  in  1`: shift enable.
- `gpio_sram_load  in  1`: load captured read data into the shift register.
- `global_csb  in  1`: active-low access strobe.
- `gpio_out  out  1`: serial data out, equal to shift register bit 111.
- `sram_csb0`, `sram_csb1`  out  NUM_SRAM: per-slot active-low chip selects.
- `sram_web0`, `sram_web1`  out  1: write enables, active-low.
- `sram_addr0`, `sram_addr1`  out  ADDR_W: addresses.
- `sram_din0`, `sram_din1`  out  32: write data.
- `sram_wmask0`, `sram_wmask1`  out  4: write masks.
- `sram_dout0`, `sram_dout1`  in  NUM_SRAM*32: flattened read data; slot k occupies bits [32k+31:32k].

## Operation
- Packet layout, bits 111 down to 0: `sel[3:0]`, `addr0[15:0]`, `din0[31:0]`, `csb0`, `web0`, `wmask0[3:0]`, `addr1[15:0]`, `din1[31:0]`, `csb1`, `web1`, `wmask1[3:0]`.
- Shift: when `gpio_scan=1`, `sr <= {sr[110:0], gpio_in}` each cycle.
- Load: when `gpio_sram_load=1`, the `din0` field is replaced by `dout0_q` and the `din1` field by `dout1_q`. All other fields are unchanged.
- Priority: `gpio_sram_load` beats `gpio_scan`; `gpio_scan` beats access.
- Access cycle: `global_csb=0` and `gpio_scan=0`.
  - The chip selects are driven combinationally: `sram_csb0[sel] = csb0` and `sram_csb1[sel] = csb1`.
  - All other chip-select bits are 1.
  - Address, data, web and wmask outputs always mirror the packet fields.
- FSM states:
  - IDLE -> ACCESS when an access cycle occurs.
  - ACCESS stays in ACCESS while access cycles continue; otherwise it returns to IDLE.
  - CAPTURE happens on every clock edge where the state is ACCESS.
- Capture rule, per port p:
  - `doutp_q <= sram_doutp[sel]` if that port read (`csbp=0`, `webp=1`) and `sel < NUM_SRAM`.
  - Otherwise `doutp_q <= 0`.
- Field values `sel`, `csbp` and `webp` are those held during the access cycle. The shift register cannot change in ACCESS, because `gpio_scan=0` is required to enter it.
- Unmapped `sel`: no chip select asserted; captured data is 0.

## Timing
- Reset: `sr=0`, `dout0_q=dout1_q=0`, FSM=IDLE, `gpio_out=0`, all `sram_csb*` outputs all-ones.
- Whenever `global_csb=1` or `gpio_scan=1`, all chip selects are 1 combinationally.
- Sequence for one access:
  - E1: `global_csb` low; the macro samples the access.
  - E2: capture.
  - E3 (or later): `gpio_sram_load` loads the captured data.
  - Next edge onward: scan-out. The first bit, `sel[3]`, is already on `gpio_out` before the first shift edge.
- Read latency: 1 cycle from the access edge to the capture edge.
- Reset during ACCESS: chip selects release immediately (asynchronous) and no capture occurs.
- Back-to-back access cycles re-access the memory each cycle; each capture holds the data of the previous cycle's access.

## Configuration
- `GPIO_SCAN_PARITY_EN`:
  - When defined:
    - The packet grows to 113 bits, with an even-parity bit at position 0 (the fields shift up by 1).
    - An output `parity_err` (1 bit) is added.
    - An access cycle whose packet has odd parity over all 113 bits asserts no chip select, performs no capture, and sets `parity_err`.
    - `parity_err` is sticky until reset.
  - When undefined: the packet is 112 bits, there is no `parity_err` port, and every access proceeds.

## Test plan
- Write then read-back, slot 3:
  - Write `addr0=1`, `din0=3`, `csb0=0`, `web0=0`; then write `addr0=2`, `din0=24`.
  - Read with `addr0=1` and `addr1=2`, both ports reading.
  - Scan-out must show `din0=3` and `din1=24`, and `sram_csb0` must be `12'hFF7` for exactly one cycle per access.
- Single-port slot 8: write `0xDEADBEEF` to address 1, then read with `csb1=1` -> scan-out `din0=0xDEADBEEF`, `din1=0`.
- ROM slot 11: read `addr0=1` with model data 255 -> `din0=255`; all other fields echo unchanged.
- Unmapped `sel=14`: access asserts no chip select; scan-out `din0=din1=0`.
- Priority: `global_csb=0` together with `gpio_scan=1` -> no chip select asserted, shift continues. `gpio_sram_load=1` together with `gpio_scan=1` -> load wins, no shift that cycle.
- Reset mid-access: drop `gpio_resetn` while `global_csb=0` -> chip selects are all-ones immediately, `gpio_out=0`, and a subsequent load yields `din` fields of 0.
